// File: rtl/fpu_uart_pkg.sv
// Shared definitions for the UART command receiver feeding the FPU control FSM.
// Contents: frame length and byte-index constants, byte-receiver state
// encoding, and the bf16 operand layout.
package fpu_uart_pkg;

    localparam int FRAME_BYTES = 5;
    localparam int IDX_W       = $clog2(FRAME_BYTES);

    typedef logic [IDX_W-1:0] byte_idx_t;

    localparam byte_idx_t IDX_OP  = 3'd0;
    localparam byte_idx_t IDX_AHI = 3'd1;
    localparam byte_idx_t IDX_ALO = 3'd2;
    localparam byte_idx_t IDX_BHI = 3'd3;
    localparam byte_idx_t IDX_BLO = 3'd4;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] man;
    } bf16_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser plus byte FSM.
// Ports:
//   clk, rst_l   system clock, synchronous active-low reset
//   rx_serial    asynchronous UART line, idle high
//   byte_data    last received byte (valid with byte_valid)
//   byte_valid   one-cycle pulse when a byte with a good stop bit arrives
//   stop_err     one-cycle pulse when the stop bit samples low
//   rx_idle      FSM is in IDLE (used by the frame timeout)
//
// state        | meaning
// RX_IDLE      | line idle, waiting for a falling edge on rx_s
// RX_START     | half a bit into the start bit, confirm it is still low
// RX_DATA      | sampling 8 data bits mid-bit, LSB first
// RX_STOP      | sampling the stop bit
// RX_WAIT_HIGH | stop bit was low, wait for the line to return high
module uart_rx_byte
    import fpu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       rx_serial,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       stop_err,
    output logic       rx_idle
);

    localparam int             CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

    logic          sync_1;
    logic          rx_s;
    rx_state_e     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    assign byte_data = shreg;
    assign rx_idle   = (state == RX_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            sync_1     <= 1'b1;
            rx_s       <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            sync_1     <= rx_serial;
            rx_s       <= sync_1;
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state <= RX_START;
                        cnt   <= HALF_LOAD;
                    end
                end
                RX_START: begin
                    if (cnt == '0) begin
                        if (!rx_s) begin
                            state   <= RX_DATA;
                            cnt     <= BIT_LOAD;
                            bit_idx <= '0;
                        end else begin
                            // too short to be a start bit
                            state <= RX_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == '0) begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= BIT_LOAD;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == '0) begin
                        if (rx_s) begin
                            byte_valid <= 1'b1;
                            state      <= RX_IDLE;
                        end else begin
                            stop_err <= 1'b1;
                            state    <= RX_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_fpu_cmd_rx.sv
// UART command front end for the FPU FSM. Assembles 5-byte frames
// (opcode, A bf16 MSB first, B bf16 MSB first) and holds each on a
// single-entry valid/ready port.
// Ports:
//   clk, rst_l    system clock, synchronous active-low reset
//   r_Rx_Serial   asynchronous UART line, idle high
//   cmd_ready     consumer accepts the held command
//   cmd_valid     complete command held
//   cmd_op/a/b    opcode and bf16 operands
//   frame_err     one-cycle pulse on bad stop bit or inter-byte timeout
//   overrun       one-cycle pulse when a frame completes while one is held
module uart_fpu_cmd_rx
    import fpu_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 16 * CLKS_PER_BIT * 10
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        r_Rx_Serial,
    input  logic        cmd_ready,
    output logic        cmd_valid,
    output logic [7:0]  cmd_op,
    output logic [15:0] cmd_a,
    output logic [15:0] cmd_b,
    output logic        frame_err,
    output logic        overrun
);

    localparam int            TW       = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CLKS - 1);

    logic [7:0]    byte_data;
    logic          byte_valid;
    logic          stop_err;
    logic          rx_idle;

    byte_idx_t     idx;
    logic [7:0]    sh_op;
    bf16_t         sh_a;
    logic [7:0]    sh_bhi;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_run;
    logic          tmo_fire;
    logic          can_load;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_l      (rst_l),
        .rx_serial  (r_Rx_Serial),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .stop_err   (stop_err),
        .rx_idle    (rx_idle)
    );

    // Timer only runs in the gap between bytes of a partially received frame.
    assign tmo_run  = rx_idle && (idx != IDX_OP);
    assign tmo_fire = tmo_run && (tmo_cnt == '0) && !byte_valid;
    assign can_load = !cmd_valid || cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            idx       <= IDX_OP;
            sh_op     <= '0;
            sh_a      <= '0;
            sh_bhi    <= '0;
            tmo_cnt   <= TMO_LOAD;
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_a     <= '0;
            cmd_b     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_err || tmo_fire;
            overrun   <= 1'b0;

            if (cmd_valid && cmd_ready) begin
                cmd_valid <= 1'b0;
            end

            if (byte_valid || !tmo_run) begin
                tmo_cnt <= TMO_LOAD;
            end else if (tmo_cnt != '0) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end

            if (stop_err || tmo_fire) begin
                idx <= IDX_OP;
            end else if (byte_valid) begin
                case (idx)
                    IDX_OP:  sh_op      <= byte_data;
                    IDX_AHI: sh_a[15:8] <= byte_data;
                    IDX_ALO: sh_a[7:0]  <= byte_data;
                    IDX_BHI: sh_bhi     <= byte_data;
                    IDX_BLO: begin
                        // a load in the same cycle as an accept keeps cmd_valid high
                        if (can_load) begin
                            cmd_valid <= 1'b1;
                            cmd_op    <= sh_op;
                            cmd_a     <= sh_a;
                            cmd_b     <= {sh_bhi, byte_data};
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    default: ;
                endcase
                idx <= (idx >= IDX_BLO) ? IDX_OP : idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_fpu_cmd_rx.sv
module tb_uart_fpu_cmd_rx;

    localparam int CPB = 8;
    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        r_Rx_Serial = 1'b1;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid;
    logic [7:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        frame_err;
    logic        overrun;

    uart_fpu_cmd_rx #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .r_Rx_Serial (r_Rx_Serial),
        .cmd_ready   (cmd_ready),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // monitor state, written only by the monitor
    int          cyc = 0;
    int          ferr_cnt = 0;
    int          ovr_cnt = 0;
    int          acc_cnt = 0;
    int          vld_cnt = 0;
    int          stab_bad = 0;
    int          last_err_cyc = 0;
    logic [7:0]  acc_op = '0;
    logic [15:0] acc_a = '0;
    logic [15:0] acc_b = '0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_op = '0;
    logic [15:0] prev_a = '0;
    logic [15:0] prev_b = '0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (frame_err) begin
            ferr_cnt     = ferr_cnt + 1;
            last_err_cyc = cyc;
        end
        if (overrun) ovr_cnt = ovr_cnt + 1;
        if (cmd_valid) vld_cnt = vld_cnt + 1;
        if (cmd_valid && cmd_ready) begin
            acc_cnt = acc_cnt + 1;
            acc_op  = cmd_op;
            acc_a   = cmd_a;
            acc_b   = cmd_b;
        end
        if (prev_hold && cmd_valid &&
            (cmd_op != prev_op || cmd_a != prev_a || cmd_b != prev_b))
            stab_bad = stab_bad + 1;
        prev_hold = cmd_valid && !cmd_ready;
        prev_op   = cmd_op;
        prev_a    = cmd_a;
        prev_b    = cmd_b;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        r_Rx_Serial = b;
        wait_clks(CPB);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
        r_Rx_Serial = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        send_byte(op, 1'b1);
        send_byte(a[15:8], 1'b1);
        send_byte(a[7:0], 1'b1);
        send_byte(b[15:8], 1'b1);
        send_byte(b[7:0], 1'b1);
        wait_clks(6);
    endtask

    int b_ferr, b_ovr, b_acc, b_vld, t0;

    initial begin
        wait_clks(4);
        rst_l = 1'b1;
        wait_clks(2);
        check_val("rst_valid", {31'd0, cmd_valid}, 32'd0);
        check_val("rst_op", {24'd0, cmd_op}, 32'd0);
        check_val("rst_ab", {cmd_a, cmd_b}, 32'd0);
        check_val("rst_err", {30'd0, frame_err, overrun}, 32'd0);

        // clean frame
        cmd_ready = 1'b1;
        b_ferr = ferr_cnt; b_ovr = ovr_cnt; b_acc = acc_cnt; b_vld = vld_cnt;
        send_frame(8'h01, 16'h3F80, 16'h4000);
        check_val("clean_acc", acc_cnt - b_acc, 1);
        check_val("clean_vld_cycles", vld_cnt - b_vld, 1);
        check_val("clean_op", {24'd0, acc_op}, 32'h01);
        check_val("clean_a", {16'd0, acc_a}, 32'h3F80);
        check_val("clean_b", {16'd0, acc_b}, 32'h4000);
        check_val("clean_errs", (ferr_cnt - b_ferr) + (ovr_cnt - b_ovr), 0);

        // backpressure and overrun
        cmd_ready = 1'b0;
        b_ovr = ovr_cnt; b_acc = acc_cnt;
        send_frame(8'h03, 16'h4040, 16'hBF80);
        check_val("bp_valid", {31'd0, cmd_valid}, 32'd1);
        check_val("bp_op", {24'd0, cmd_op}, 32'h03);
        send_frame(8'h02, 16'hC000, 16'h3F00);
        check_val("bp_overrun", ovr_cnt - b_ovr, 1);
        check_val("bp_hold_op", {24'd0, cmd_op}, 32'h03);
        check_val("bp_hold_ab", {cmd_a, cmd_b}, 32'h4040BF80);
        check_val("bp_stable", stab_bad, 0);
        cmd_ready = 1'b1;
        wait_clks(3);
        check_val("bp_acc", acc_cnt - b_acc, 1);
        check_val("bp_acc_cmd", {acc_op, acc_a, acc_b[15:8]}, {8'h03, 16'h4040, 8'hBF});
        check_val("bp_drop", {31'd0, cmd_valid}, 32'd0);

        // bad stop bit on byte 2 of a frame
        b_ferr = ferr_cnt; b_acc = acc_cnt;
        send_byte(8'h04, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h00, 1'b0);
        wait_clks(10);
        check_val("stop_ferr", ferr_cnt - b_ferr, 1);
        check_val("stop_nocmd", acc_cnt - b_acc, 0);
        send_frame(8'h05, 16'h3FC0, 16'hC120);
        check_val("stop_next_acc", acc_cnt - b_acc, 1);
        check_val("stop_next_cmd", {acc_op, acc_a, acc_b[15:8]}, {8'h05, 16'h3FC0, 8'hC1});
        check_val("stop_next_blo", {24'd0, acc_b[7:0]}, 32'h20);

        // glitch on idle line
        b_ferr = ferr_cnt; b_acc = acc_cnt;
        r_Rx_Serial = 1'b0;
        wait_clks(2);
        r_Rx_Serial = 1'b1;
        wait_clks(20);
        check_val("glitch_ferr", ferr_cnt - b_ferr, 0);
        send_frame(8'h09, 16'h4110, 16'h0001);
        check_val("glitch_acc", acc_cnt - b_acc, 1);
        check_val("glitch_cmd", {acc_op, acc_a, acc_b[15:8]}, {8'h09, 16'h4110, 8'h00});

        // inter-byte timeout
        b_ferr = ferr_cnt; b_acc = acc_cnt;
        send_byte(8'h0A, 1'b1);
        send_byte(8'h0B, 1'b1);
        send_byte(8'h0C, 1'b1);
        t0 = cyc;
        wait_clks(250);
        check_val("tmo_ferr", ferr_cnt - b_ferr, 1);
        check_val("tmo_window", ((last_err_cyc - t0) >= 195 && (last_err_cyc - t0) <= 205) ? 1 : 0, 1);
        check_val("tmo_nocmd", acc_cnt - b_acc, 0);
        send_frame(8'h06, 16'h4080, 16'h3F80);
        check_val("tmo_next_acc", acc_cnt - b_acc, 1);
        check_val("tmo_next_cmd", {acc_op, acc_a, acc_b[15:8]}, {8'h06, 16'h4080, 8'h3F});

        // reset with a held command and a partial frame
        cmd_ready = 1'b0;
        send_frame(8'h07, 16'h3F80, 16'h3F80);
        check_val("rstm_held", {31'd0, cmd_valid}, 32'd1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        rst_l = 1'b0;
        wait_clks(1);
        rst_l = 1'b1;
        wait_clks(1);
        check_val("rstm_valid", {31'd0, cmd_valid}, 32'd0);
        check_val("rstm_outs", {cmd_a, cmd_b}, 32'd0);
        check_val("rstm_op", {24'd0, cmd_op}, 32'd0);
        cmd_ready = 1'b1;
        b_acc = acc_cnt;
        send_frame(8'h08, 16'h4100, 16'h4200);
        check_val("rstm_acc", acc_cnt - b_acc, 1);
        check_val("rstm_cmd", {acc_op, acc_a, acc_b[15:8]}, {8'h08, 16'h4100, 8'h42});
        check_val("rstm_blo", {24'd0, acc_b[7:0]}, 32'h00);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
